oled_cmd_sender: RTL
====================

Name: oled_cmd_sender

Overview:
- Consumer end of the command-descriptor interface (command index -> comm_length/comm_data) used for OLED bring-up.
- On start, walks command indices 0,1,2,... and fetches each descriptor from the combinational command table.
- Serialises each descriptor's bytes to the SSD1331 over 4-wire SPI: mode 0, MSB first, D/C low, one CS frame per command.
- Stops at the first descriptor with length 0, then reports done.

Parameters:
- CLK_DIV, 5: system clocks per SCLK half-period; must be >= 1.
- GAP_CYCLES, 100: idle clocks with CS high between commands; must be >= 1 and also covers clear-window settle time.
- MAX_CMDS, 32: hard stop on command index, independent of the terminator.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  one-cycle pulse that begins the sequence
- command_out  output  5  descriptor index driven to the command table
- comm_length_in  input  4  byte count of the current descriptor; 0 = end of table
- comm_data_in  input  120  descriptor bytes, first byte in [119:112]
- busy_out  output  1  high from the start pulse through the last gap
- done_out  output  1  level; high after the sequence ends until the next start
- cs_n_out  output  1  SPI chip select, active low
- sclk_out  output  1  SPI clock
- mosi_out  output  1  SPI data
- dc_out  output  1  data/command select; 0 = command

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE
  - command_out=0, busy_out=0, done_out=0
  - cs_n_out=1, sclk_out=0, mosi_out=0, dc_out=0
  - All counters cleared.
  - Reset asserted mid-frame aborts the frame immediately; there is no resume.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, SHIFT, GAP, DONE.
- IDLE/DONE + start_in:
  - command_out<=0, busy_out<=1, done_out<=0, next state FETCH.
  - start_in in any other state is ignored.
- FETCH: one settle cycle for the table output, then LOAD.
- LOAD:
  - If comm_length_in==0 or command_out==MAX_CMDS-1 with length 0 -> DONE.
  - Otherwise latch comm_data_in into a 120-bit shift register and bit_cnt<=8*comm_length_in.
  - Next cycle: cs_n_out<=0, mosi_out<=shift[119], sclk_out<=0.
- SHIFT (mode 0):
  - sclk_out low for CLK_DIV clocks, then high for CLK_DIV clocks.
  - mosi_out changes only when sclk_out falls (and on frame entry); the shift register shifts left by 1 at each falling edge.
  - Frame length is exactly 16*CLK_DIV*len clocks with cs_n_out low.
  - After the final high phase: sclk_out<=0 and cs_n_out<=1 in the same cycle, then GAP.
- GAP:
  - Count GAP_CYCLES clocks, then command_out<=command_out+1 and go to FETCH.
  - If command_out==MAX_CMDS-1, go to DONE instead; no wrap to 0.
- DONE: busy_out<=0, done_out<=1, cs_n_out=1; a new start_in restarts from index 0.
- dc_out is held 0 for the entire sequence; it is reserved for a later pixel-data path.
- Lengths 1..15 are all legal. comm_data_in bits beyond 8*len are never shifted out.

Decomposition:
- Package oled_pkg holds:
  - state enum oled_tx_state_t
  - constants CMD_MAX_BYTES=15, CMD_DATA_W=120, CMD_IDX_W=5, CMD_LEN_W=4
- Natural sub-module: oled_spi_shifter.
  - Owns the shift register, bit counter and SCLK divider.
  - Interface: load/len/data in; sclk/mosi/frame_done out.
  - The parent FSM owns indexing, CS and gaps.

Test Plan:
- Full sequence against the real command table (CLK_DIV=2, GAP_CYCLES=4):
  - exactly 25 CS frames and 51 bytes total
  - byte stream begins FD 12 | AE | A0 60 | A1 00 and ends 25 00 00 5F 3F | AF
  - done_out rises after the last gap; busy_out then falls.
- Single 1-byte descriptor 0xA5 (stub table, CLK_DIV=3):
  - cs_n low for exactly 48 clocks
  - 8 rising SCLK edges sample 1,0,1,0,0,1,0,1
  - mosi stable ±3 clocks around each rising edge.
- Stub table returning length 0 at index 0: no CS activity, done_out high 3 clocks after start_in.
- start_in pulsed during SHIFT of command 2: ignored, sequence and byte count unchanged.
- rst_n_in asserted mid-byte of command 5:
  - same clock: cs_n_out=1, sclk_out=0, busy_out=0
  - a subsequent start_in restarts at index 0 with FD 12.
- Stub table always returning length 15: stops after 32 frames (MAX_CMDS), 480 bytes, command_out holds 31, done_out=1.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and sizes for the OLED command-descriptor sender.
// Descriptor bytes are left-aligned in CMD_DATA_W bits; the first byte sits in the top 8 bits.
package oled_pkg;

  localparam int CMD_MAX_BYTES = 15;
  localparam int CMD_DATA_W    = 120;
  localparam int CMD_IDX_W     = 5;
  localparam int CMD_LEN_W     = 4;
  localparam int CMD_BITS_W    = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } oled_tx_state_t;

  function automatic logic [CMD_BITS_W-1:0] len_to_bits(input logic [CMD_LEN_W-1:0] len);
    return {len, 3'b000};
  endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// SPI mode-0 serialiser: MSB first, SCLK low then high for CLK_DIV clocks each per bit.
// frame_done flags the clock edge that ends the final high phase, so the parent can raise CS on it.
module oled_spi_shifter
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [CMD_LEN_W-1:0]  len,
  input  logic [CMD_DATA_W-1:0] data,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [CMD_DATA_W-1:0] shift_r;
  logic [CMD_BITS_W-1:0] bit_cnt_r;
  logic [DIV_W-1:0]      div_cnt_r;
  logic                  sclk_r;
  logic                  active_r;
  logic                  frame_done_s;

  // mosi is the top of the shift register, so it is registered and only moves on load or a falling SCLK
  assign sclk       = sclk_r;
  assign mosi       = shift_r[CMD_DATA_W-1];
  assign frame_done = frame_done_s;

  // Last edge of the frame: end of the high phase of the final bit
  always_comb begin
    frame_done_s = 1'b0;
    if (active_r && sclk_r && (div_cnt_r == DIV_LAST) && (bit_cnt_r == 7'd1)) begin
      frame_done_s = 1'b1;
    end else begin
      frame_done_s = 1'b0;
    end
  end

  // Shift register, bit counter and SCLK divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= {CMD_DATA_W{1'b0}};
      bit_cnt_r <= {CMD_BITS_W{1'b0}};
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b0;
      active_r  <= 1'b0;
    end else if (load) begin
      shift_r   <= data;
      bit_cnt_r <= len_to_bits(len);
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b0;
      active_r  <= 1'b1;
    end else if (active_r) begin
      if (div_cnt_r != DIV_LAST) begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end else begin
        div_cnt_r <= {DIV_W{1'b0}};
        if (!sclk_r) begin
          sclk_r <= 1'b1;
        end else if (frame_done_s) begin
          // Clearing the register parks mosi low and keeps unsent descriptor bits off the wire
          sclk_r    <= 1'b0;
          active_r  <= 1'b0;
          shift_r   <= {CMD_DATA_W{1'b0}};
          bit_cnt_r <= {CMD_BITS_W{1'b0}};
        end else begin
          sclk_r    <= 1'b0;
          shift_r   <= {shift_r[CMD_DATA_W-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r - 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_cmd_sender.sv
// Walks the command table from index 0, sending each descriptor as one CS frame to the SSD1331,
// until a zero-length descriptor or the last permitted index.
module oled_cmd_sender
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = 5,
  parameter int GAP_CYCLES = 100,
  parameter int MAX_CMDS   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  output logic [CMD_IDX_W-1:0]  command_out,
  input  logic [CMD_LEN_W-1:0]  comm_length_in,
  input  logic [CMD_DATA_W-1:0] comm_data_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  cs_n_out,
  output logic                  sclk_out,
  output logic                  mosi_out,
  output logic                  dc_out
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CMD_IDX_W-1:0] LAST_IDX = CMD_IDX_W'(MAX_CMDS - 1);

  oled_tx_state_t       state_r;
  logic [CMD_IDX_W-1:0] command_r;
  logic [GAP_W-1:0]     gap_cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 cs_n_r;
  logic                 dc_r;
  logic                 load_s;
  logic                 frame_done_s;
  logic                 sclk_s;
  logic                 mosi_s;

  assign command_out = command_r;
  assign busy_out    = busy_r;
  assign done_out    = done_r;
  assign cs_n_out    = cs_n_r;
  assign sclk_out    = sclk_s;
  assign mosi_out    = mosi_s;
  assign dc_out      = dc_r;

  // Start the serialiser on the same edge the FSM leaves LOAD with a non-empty descriptor
  always_comb begin
    load_s = 1'b0;
    if ((state_r == ST_LOAD) && (comm_length_in != {CMD_LEN_W{1'b0}})) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  oled_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .load       (load_s),
    .len        (comm_length_in),
    .data       (comm_data_in),
    .sclk       (sclk_s),
    .mosi       (mosi_s),
    .frame_done (frame_done_s)
  );

  // Sequencer: indexing, chip select, inter-command gap and status flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= ST_IDLE;
      command_r <= {CMD_IDX_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      dc_r      <= 1'b0;
    end else begin
      dc_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            command_r <= {CMD_IDX_W{1'b0}};
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= ST_FETCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          if (comm_length_in == {CMD_LEN_W{1'b0}}) begin
            state_r <= ST_DONE;
          end else begin
            cs_n_r  <= 1'b0;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (frame_done_s) begin
            cs_n_r    <= 1'b1;
            gap_cnt_r <= {GAP_W{1'b0}};
            state_r   <= ST_GAP;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= {GAP_W{1'b0}};
            if (command_r == LAST_IDX) begin
              state_r <= ST_DONE;
            end else begin
              command_r <= command_r + CMD_IDX_W'(1);
              state_r   <= ST_FETCH;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        ST_DONE: begin
          cs_n_r <= 1'b1;
          if (start_in) begin
            command_r <= {CMD_IDX_W{1'b0}};
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= ST_FETCH;
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cs_n_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule
